// File: rtl/free_list_pkg.sv
// Shared rename package: register-index typedefs, free-list sizing and circular pointer helper.
// Used by the free list, ROB and map tables.
package free_list_pkg;

  localparam int unsigned PHYS_REGS      = 128;
  localparam int unsigned ARCH_REGS      = 64;
  localparam int unsigned FL_DEPTH       = PHYS_REGS - ARCH_REGS;
  localparam int unsigned DISPATCH_WIDTH = 1;
  localparam int unsigned COMMIT_WIDTH   = 1;

  localparam int unsigned PRF_W  = $clog2(PHYS_REGS);
  localparam int unsigned ARCH_W = $clog2(ARCH_REGS);
  localparam int unsigned PTR_W  = $clog2(FL_DEPTH);
  localparam int unsigned CNT_W  = $clog2(FL_DEPTH + 1);
  localparam int unsigned SUM_W  = CNT_W + 1;

  typedef logic [PRF_W-1:0]  prf_idx_t;
  typedef logic [ARCH_W-1:0] arch_idx_t;
  typedef logic [PTR_W-1:0]  fl_ptr_t;
  typedef logic [CNT_W-1:0]  fl_cnt_t;

  // Pointer advance with explicit wrap so FL_DEPTH need not be a power of two.
  function automatic fl_ptr_t fl_ptr_add(input fl_ptr_t ptr, input fl_cnt_t off);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(ptr) + SUM_W'(off);
    if (sum >= SUM_W'(FL_DEPTH)) begin
      sum = sum - SUM_W'(FL_DEPTH);
    end
    return PTR_W'(sum);
  endfunction

endpackage

// File: rtl/free_list_if.sv
// Dispatch/commit/flush signal bundle between the rename stage and the free list.
interface free_list_if;
  import free_list_pkg::*;

  logic     [DISPATCH_WIDTH-1:0] alloc_req_i;
  logic     [DISPATCH_WIDTH-1:0] alloc_gnt_o;
  prf_idx_t [DISPATCH_WIDTH-1:0] alloc_prf_o;
  fl_cnt_t                       free_count_o;
  logic     [COMMIT_WIDTH-1:0]   commit_valid_i;
  logic     [COMMIT_WIDTH-1:0]   commit_rd_wen_i;
  prf_idx_t [COMMIT_WIDTH-1:0]   commit_old_prf_i;
  logic                          flush_i;

  modport master (
    output alloc_req_i, commit_valid_i, commit_rd_wen_i, commit_old_prf_i, flush_i,
    input  alloc_gnt_o, alloc_prf_o, free_count_o
  );

  modport slave (
    input  alloc_req_i, commit_valid_i, commit_rd_wen_i, commit_old_prf_i, flush_i,
    output alloc_gnt_o, alloc_prf_o, free_count_o
  );

endinterface

// File: rtl/free_list.sv
// R10K physical-register free list with a retirement head for instant flush recovery.
module free_list
  import free_list_pkg::*;
(
  input logic        clock,
  input logic        reset,
  free_list_if.slave fl
);

  prf_idx_t entries [FL_DEPTH];
  fl_ptr_t  head;
  fl_ptr_t  retire_head;
  fl_ptr_t  tail;
  fl_cnt_t  count;

  fl_cnt_t                 granted;
  fl_cnt_t                 freed;
  fl_cnt_t                 retired;
  logic [COMMIT_WIDTH-1:0] wen;
  logic [COMMIT_WIDTH-1:0] drop;
  fl_ptr_t                 widx [COMMIT_WIDTH];
  fl_ptr_t                 retire_head_next;
  fl_ptr_t                 tail_next;

  // Zero-latency grants from registered state; an ungranted lane does not block later ones.
  always_comb begin
    granted        = '0;
    fl.alloc_gnt_o = '0;
    fl.alloc_prf_o = '0;
    for (int unsigned i = 0; i < DISPATCH_WIDTH; i++) begin
      if (fl.alloc_req_i[i] && !fl.flush_i && !reset && (granted < count)) begin
        fl.alloc_gnt_o[i] = 1'b1;
        fl.alloc_prf_o[i] = entries[fl_ptr_add(head, granted)];
        granted           = granted + fl_cnt_t'(1);
      end
    end
  end

  // Free offsets; a free into an already-full list is dropped but still counts as a retirement.
  always_comb begin
    freed   = '0;
    retired = '0;
    wen     = '0;
    drop    = '0;
    for (int unsigned k = 0; k < COMMIT_WIDTH; k++) begin
      widx[k] = fl_ptr_add(tail, freed);
      if (fl.commit_valid_i[k] && fl.commit_rd_wen_i[k]) begin
        retired = retired + fl_cnt_t'(1);
        if ((SUM_W'(count) + SUM_W'(freed)) >= SUM_W'(FL_DEPTH)) begin
          drop[k] = 1'b1;
        end else begin
          wen[k] = 1'b1;
          freed  = freed + fl_cnt_t'(1);
        end
      end
    end
    retire_head_next = fl_ptr_add(retire_head, retired);
    tail_next        = fl_ptr_add(tail, freed);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < FL_DEPTH; i++) begin
        entries[i] <= prf_idx_t'(ARCH_REGS + i);
      end
      head        <= '0;
      retire_head <= '0;
      tail        <= '0;
      count       <= fl_cnt_t'(FL_DEPTH);
    end else begin
      for (int unsigned k = 0; k < COMMIT_WIDTH; k++) begin
        if (wen[k]) begin
          entries[widx[k]] <= fl.commit_old_prf_i[k];
        end
      end
      tail        <= tail_next;
      retire_head <= retire_head_next;
      if (fl.flush_i) begin
        head  <= retire_head_next;
        count <= fl_cnt_t'(FL_DEPTH);
      end else begin
        head  <= fl_ptr_add(head, granted);
        count <= count + freed - granted;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && (|drop)) begin
      $error("free_list: tag freed while list already full, write dropped");
    end
  end

  assign fl.free_count_o = count;

endmodule
